// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RISC-V control FSM driving datapath mux selects, write enables and memory handshake.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module mc_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [2:0]       result_sel,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [WIDTH-1:0] cycle_cnt,
  output logic [WIDTH-1:0] instret_cnt
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_sel;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] res;
    logic [1:0] op;
    logic       reg_write;
  } ctl_t;
  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   illegal_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b1100011:             state_d = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          7'b1101111:             state_d = JAL;
          7'b0110111:             state_d = LUI;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXEC_R:   state_d = ALUWB;
      EXEC_I:   state_d = ALUWB;
      JAL:      state_d = ALUWB;
      MEMWB:    state_d = FETCH;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      LUI:      state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
    if (!rst_n) state_d = FETCH;
  end
  // Moore controls are precomputed from the next state so they come straight out of flops.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      FETCH:    begin ctl_d.mem_req = 1'b1; ctl_d.b = 2'd2; ctl_d.res = 3'd2; end
      DECODE:   begin ctl_d.a = 2'd1; ctl_d.b = 2'd1; end
      MEMADR:   begin ctl_d.a = 2'd2; ctl_d.b = 2'd1; end
      MEMREAD:  begin ctl_d.mem_req = 1'b1; ctl_d.adr_sel = 1'b1; end
      MEMWB:    begin ctl_d.res = 3'd1; ctl_d.reg_write = 1'b1; end
      MEMWRITE: begin ctl_d.mem_req = 1'b1; ctl_d.adr_sel = 1'b1; ctl_d.mem_we = 1'b1; end
      EXEC_R:   begin ctl_d.a = 2'd2; ctl_d.op = 2'b10; end
      EXEC_I:   begin ctl_d.a = 2'd2; ctl_d.b = 2'd1; ctl_d.op = 2'b10; end
      ALUWB:    ctl_d.reg_write = 1'b1;
      BRANCH:   begin ctl_d.a = 2'd2; ctl_d.op = 2'b01; end
      JAL:      begin ctl_d.a = 2'd1; ctl_d.b = 2'd2; end
      LUI:      begin ctl_d.res = 3'd3; ctl_d.reg_write = 1'b1; end
      default:  ctl_d = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    ctl_q     <= ctl_d;
    illegal_q <= rst_n && (illegal_q || state_d == TRAP);
  end
  assign mem_req    = rst_n & ctl_q.mem_req;
  assign mem_we     = rst_n & ctl_q.mem_we;
  assign adr_sel    = rst_n & ctl_q.adr_sel;
  assign alu_a_sel  = rst_n ? ctl_q.a : 2'd0;
  assign alu_b_sel  = rst_n ? ctl_q.b : 2'd0;
  assign result_sel = rst_n ? ctl_q.res : 3'd0;
  assign alu_op     = rst_n ? ctl_q.op : 2'd0;
  assign reg_write  = rst_n & ctl_q.reg_write;
  assign ir_write   = rst_n && state_q == FETCH && mem_ready;
  assign pc_write   = rst_n && (state_q == FETCH  ? mem_ready :
                                state_q == BRANCH ? (zero ^ funct3[0]) :
                                state_q == JAL);
  assign illegal    = illegal_q;
`ifdef MC_PERF_CNT_EN
  logic [WIDTH-1:0] cycle_q, instret_q;
  logic             retire;
  assign retire = state_q == MEMWB || state_q == ALUWB || state_q == BRANCH ||
                  state_q == LUI || (state_q == MEMWRITE && mem_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != TRAP) begin
      cycle_q   <= cycle_q + WIDTH'(1);
      instret_q <= instret_q + WIDTH'(retire);
    end
  end
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle check of mc_ctrl outputs plus trap, reset and counter sequences.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, adr_sel, pc_write, ir_write, reg_write, illegal;
  logic [1:0]  alu_a_sel, alu_b_sel, alu_op;
  logic [2:0]  result_sel;
  logic [31:0] cycle_cnt, instret_cnt;
  int checks = 0, errors = 0;

  mc_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_sel(adr_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .result_sel(result_sel),
    .alu_op(alu_op), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [15:0] ex;
  } vec_t;
  vec_t v[$];

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  // {mem_req, mem_we, adr_sel, alu_a, alu_b, result_sel, alu_op, pc_write, ir_write, reg_write, illegal}
  function automatic logic [15:0] e(bit rq, bit we, bit ad, int a, int b, int rs, int op,
                                    bit pc, bit ir, bit rw, bit il);
    return {rq, we, ad, 2'(a), 2'(b), 3'(rs), 2'(op), pc, ir, rw, il};
  endfunction

  function automatic logic [15:0] act();
    return {mem_req, mem_we, adr_sel, alu_a_sel, alu_b_sel, result_sel, alu_op,
            pc_write, ir_write, reg_write, illegal};
  endfunction

  task automatic add(bit r, logic [6:0] op, logic [2:0] f3, bit z, bit mr, logic [15:0] ex);
    v.push_back('{r, op, f3, z, mr, ex});
  endtask

  task automatic drive(bit r, logic [6:0] op, logic [2:0] f3, bit z, bit mr);
    rst_n = r; opcode = op; funct3 = f3; zero = z; mem_ready = mr;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  logic [15:0] z0, fw, fr, dc, mrd, mwr;

  initial begin
    z0  = '0;
    fw  = e(1,0,0,0,2,2,0,0,0,0,0);
    fr  = e(1,0,0,0,2,2,0,1,1,0,0);
    dc  = e(0,0,0,1,1,0,0,0,0,0,0);
    mrd = e(1,0,1,0,0,0,0,0,0,0,0);
    mwr = e(1,1,1,0,0,0,0,0,0,0,0);
    // reset held two cycles, then fetch stalls for memory
    add(0, OP_R, 0, 0, 1, z0);
    add(0, OP_R, 0, 0, 1, z0);
    add(1, OP_R, 0, 0, 0, fw);
    add(1, OP_R, 0, 0, 1, fr);
    add(1, OP_R, 0, 0, 1, dc);
    add(1, OP_R, 0, 0, 1, e(0,0,0,2,0,0,2,0,0,0,0));
    add(1, OP_R, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,1,0));
    // load with three wait states
    add(1, OP_LW, 2, 0, 1, fr);
    add(1, OP_LW, 2, 0, 1, dc);
    add(1, OP_LW, 2, 0, 1, e(0,0,0,2,1,0,0,0,0,0,0));
    add(1, OP_LW, 2, 0, 0, mrd);
    add(1, OP_LW, 2, 0, 0, mrd);
    add(1, OP_LW, 2, 0, 0, mrd);
    add(1, OP_LW, 2, 0, 1, mrd);
    add(1, OP_LW, 2, 0, 1, e(0,0,0,0,0,1,0,0,0,1,0));
    // BNE taken then not taken
    add(1, OP_BR, 1, 0, 1, fr);
    add(1, OP_BR, 1, 0, 1, dc);
    add(1, OP_BR, 1, 0, 1, e(0,0,0,2,0,0,1,1,0,0,0));
    add(1, OP_BR, 1, 1, 1, fr);
    add(1, OP_BR, 1, 1, 1, dc);
    add(1, OP_BR, 1, 1, 1, e(0,0,0,2,0,0,1,0,0,0,0));
    // BEQ taken on zero
    add(1, OP_BR, 0, 1, 1, fr);
    add(1, OP_BR, 0, 1, 1, dc);
    add(1, OP_BR, 0, 1, 1, e(0,0,0,2,0,0,1,1,0,0,0));
    // JAL
    add(1, OP_JAL, 0, 0, 1, fr);
    add(1, OP_JAL, 0, 0, 1, dc);
    add(1, OP_JAL, 0, 0, 1, e(0,0,0,1,2,0,0,1,0,0,0));
    add(1, OP_JAL, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,1,0));
    // LUI
    add(1, OP_LUI, 0, 0, 1, fr);
    add(1, OP_LUI, 0, 0, 1, dc);
    add(1, OP_LUI, 0, 0, 1, e(0,0,0,0,0,3,0,0,0,1,0));
    // ADDI
    add(1, OP_I, 0, 0, 1, fr);
    add(1, OP_I, 0, 0, 1, dc);
    add(1, OP_I, 0, 0, 1, e(0,0,0,2,1,0,2,0,0,0,0));
    add(1, OP_I, 0, 0, 1, e(0,0,0,0,0,0,0,0,0,1,0));
    // store completing, then store abandoned by reset while waiting
    add(1, OP_SW, 2, 0, 1, fr);
    add(1, OP_SW, 2, 0, 1, dc);
    add(1, OP_SW, 2, 0, 1, e(0,0,0,2,1,0,0,0,0,0,0));
    add(1, OP_SW, 2, 0, 1, mwr);
    add(1, OP_SW, 2, 0, 1, fr);
    add(1, OP_SW, 2, 0, 1, dc);
    add(1, OP_SW, 2, 0, 0, e(0,0,0,2,1,0,0,0,0,0,0));
    add(1, OP_SW, 2, 0, 0, mwr);
    add(1, OP_SW, 2, 0, 0, mwr);
    add(0, OP_SW, 2, 0, 1, z0);
    add(1, OP_SW, 2, 0, 0, fw);
    add(1, OP_SW, 2, 0, 0, fw);
    // branch with unsupported funct3 traps
    add(1, OP_BR, 3'b100, 0, 1, fr);
    add(1, OP_BR, 3'b100, 0, 1, dc);
    add(1, OP_BR, 3'b100, 0, 1, e(0,0,0,0,0,0,0,0,0,0,1));
    add(0, OP_BR, 3'b100, 0, 1, e(0,0,0,0,0,0,0,0,0,0,1));
    add(1, OP_BR, 3'b100, 0, 0, fw);
    // illegal opcode into trap
    add(1, OP_BAD, 0, 0, 1, fr);
    add(1, OP_BAD, 0, 0, 1, dc);

    drive(0, OP_R, 0, 0, 1);
    next();
    foreach (v[i]) begin
      drive(v[i].r, v[i].op, v[i].f3, v[i].z, v[i].mr);
      @(negedge clk);
      chk($sformatf("row%0d", i), 32'(act()), 32'(v[i].ex));
      next();
    end

    // trap must stay quiet and flagged despite mem_ready
    for (int k = 0; k < 10; k++) begin
      drive(1, OP_BAD, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("trap_req%0d", k), 32'(mem_req), 32'd0);
      chk($sformatf("trap_ill%0d", k), 32'(illegal), 32'd1);
      next();
    end
    drive(0, OP_BAD, 0, 0, 1);
    next();
    drive(1, OP_R, 0, 0, 0);
    @(negedge clk);
    chk("trap_clear", 32'(illegal), 32'd0);
    chk("trap_refetch", 32'(act()), 32'(fw));
    next();

`ifdef MC_PERF_CNT_EN
    drive(0, OP_R, 0, 0, 1);
    next();
    drive(1, OP_R, 0, 0, 1);
    repeat (4) next();
    @(negedge clk);
    chk("cycle_cnt", cycle_cnt, 32'd4);
    chk("instret_cnt", instret_cnt, 32'd1);
`else
    @(negedge clk);
    chk("cycle_cnt_tied", cycle_cnt, 32'd0);
    chk("instret_cnt_tied", instret_cnt, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
